mult_host_seq: RTL and testbench
================================

// Module: mult_host_seq
// PURPOSE
//  Host-side sequencer for the 8x8 multiplier control FSM: accepts operand pairs over a valid/ready
//  input port, drives operands to the datapath, issues the one-cycle start pulse and the 4-bit
//  step count the control FSM checks, and samples done. It then captures the 16-bit product and
//  returns it over a valid/ready output port. Missing done triggers a bounded retry.
// PARAMETERS
//  MAX_RETRY  2  re-issues of start after a missing done before an error result is reported
// PORTS
//  clk          in   1   clock, all state changes on rising edge
//  reset_a      in   1   asynchronous, active-high reset
//  in_valid     in   1   operand pair a_in/b_in present
//  in_ready     out  1   sequencer can accept an operand pair
//  a_in         in   8   multiplicand
//  b_in         in   8   multiplier
//  dataa        out  8   registered operand A to datapath, held stable from accept to next accept
//  datab        out  8   registered operand B to datapath, held stable from accept to next accept
//  start        out  1   start request to control FSM, registered
//  count        out  4   step count to control FSM, registered
//  done         in   1   calc-done indication from control FSM, combinational on its side
//  product_in   in   16  datapath product register
//  out_valid    out  1   product_out/out_err valid
//  out_ready    in   1   consumer accepts result
//  product_out  out  16  captured product; 0 on error
//  out_err      out  1   1 = done never observed within MAX_RETRY+1 attempts
//  busy         out  1   1 in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, in_ready=0 while reset_a high, state=IDLE, retry_cnt=0.
//    An asynchronous reset mid-operation aborts the transaction and discards its result.
//  States: IDLE, START, RUN, CHECK, OUT (registered FSM).
//  IDLE: in_ready=1, start=0, count=0. On in_valid, latch a_in/b_in into dataa/datab,
//    clear retry_cnt and go to START.
//  START: one cycle, start=1, count=0. Next state is RUN.
//  RUN: start=0; count=0 in the first RUN cycle, then +1 per cycle, 16 cycles total.
//    In the cycle with count=15 the next state is CHECK.
//    The control FSM moves lsb..msb in lockstep; count must never skip, repeat or stall.
//  CHECK: one cycle, start=0, count=0.
//    done=1: capture product_in into product_out, set out_err=0, go to OUT.
//    done=0 and retry_cnt<MAX_RETRY: increment retry_cnt, go to START.
//      The control FSM is in err and recovers on start.
//    done=0 and retry_cnt=MAX_RETRY: set product_out=0, out_err=1, go to OUT.
//  OUT: out_valid=1, outputs held. On out_ready, clear out_valid and go to IDLE.
//    There is no same-cycle back-to-back accept.
//  Latency: accept in cycle T gives start=1 at T+1, count=0 at T+2, count=15 at T+17,
//    done sampled at T+18, out_valid=1 from T+19. The fault-free path takes 19 cycles.
//  Each retry adds 18 cycles.
//  in_valid outside IDLE is ignored (in_ready=0); the operand pair is not consumed.
//  out_ready outside OUT is ignored.
//  The sequencer never asserts start in the CHECK cycle, so the control FSM returns calc_done->idle.
//  count is 4-bit and never wraps inside RUN. The exit at 15 is decided on the registered count value.
// TESTING
//  1 a=0xFF,b=0xFF, FSM model asserts done at T+18 -> out_valid at T+19, product_out=0xFE01, out_err=0.
//  2 Check the start/count trace for any pair -> start high only at T+1; count 0,1,...,15 over T+2..T+17; count=0 elsewhere.
//  3 Model suppresses done on attempt 1 only, MAX_RETRY=2 -> second start at T+19, result at T+37, out_err=0.
//  4 Model never asserts done -> 3 start pulses, then out_valid with out_err=1 and product_out=0x0000.
//  5 Hold out_ready=0 for 5 cycles in OUT, with in_valid=1 throughout -> result stable, in_ready=0; accept only after return to IDLE.
//  6 Pulse reset_a at count=7 -> all outputs 0 immediately, IDLE; a following a=0x12,b=0x34 yields 0x03A8.

Source files
------------

// File: rtl/mult_host_seq_if.sv
// Host-side handshake bundle for mult_host_seq.
//
// Handshake rule for both directions: a transfer happens on the rising clock
// edge where valid and ready are both high. A producer keeps valid and its
// data stable until that transfer. Ready does not depend combinationally on
// valid.
//
//   in_valid/in_ready    operand pair a_in/b_in, host -> sequencer
//   out_valid/out_ready  result product_out/out_err, sequencer -> host
//
// Modports:
//   master  the host side (drives operands, consumes results)
//   slave   the sequencer side
interface mult_host_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product_out;
  logic        out_err;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, product_out, out_err
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, product_out, out_err
  );
endinterface

// File: rtl/mult_host_seq.sv
// Host-side sequencer for the 8x8 multiplier control FSM.
//
// Accepts an operand pair on host.in_*, holds it on dataa/datab, pulses start
// for one cycle, then walks count through 0..15 (one step per cycle) while the
// control FSM shifts through the multiplier bits. In the cycle after count=15
// it samples done: on done the product is captured and returned on host.out_*;
// without done it restarts the same operands, up to MAX_RETRY times, before
// returning an error result (product 0, out_err 1).
//
// Ports:
//   clk, reset_a    clock (rising edge) and asynchronous active-high reset
//   host            slave side of mult_host_seq_if (operand in, result out)
//   dataa, datab    operands to the datapath, stable from accept to next accept
//   start           one-cycle start request to the control FSM
//   count           step count to the control FSM
//   done            calc-done from the control FSM
//   product_in      datapath product register
//   busy            high in every state except IDLE
//   state_dbg       current FSM state encoding
module mult_host_seq #(
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                clk,
  input  logic                reset_a,
  mult_host_seq_if.slave      host,
  output logic [7:0]          dataa,
  output logic [7:0]          datab,
  output logic                start,
  output logic [3:0]          count,
  input  logic                done,
  input  logic [15:0]         product_in,
  output logic                busy,
  output logic [2:0]          state_dbg
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t          state_q;
  logic [RW-1:0]   retry_q;
  logic [7:0]      dataa_q;
  logic [7:0]      datab_q;
  logic            start_q;
  logic [3:0]      count_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [15:0]     product_q;
  logic            err_q;
  logic            busy_q;

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q     <= IDLE;
      retry_q     <= '0;
      dataa_q     <= '0;
      datab_q     <= '0;
      start_q     <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready comes up one cycle after reset release; accept only
          // once it has been shown to the host.
          if (in_ready_q && host.in_valid) begin
            dataa_q    <= host.a_in;
            datab_q    <= host.b_in;
            retry_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            start_q    <= 1'b1;
            state_q    <= START;
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        START: begin
          start_q <= 1'b0;
          count_q <= '0;
          state_q <= RUN;
        end

        RUN: begin
          // Exit is decided on the registered value, so count shows every
          // value 0..15 exactly once and never wraps.
          if (count_q == 4'd15) begin
            count_q <= '0;
            state_q <= CHECK;
          end else begin
            count_q <= count_q + 4'd1;
          end
        end

        CHECK: begin
          // start stays low here so the control FSM can leave calc_done.
          if (done) begin
            product_q   <= product_in;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            // Control FSM sits in err and recovers on the next start.
            retry_q <= retry_q + RW'(1);
            start_q <= 1'b1;
            state_q <= START;
          end else begin
            product_q   <= '0;
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end

        OUT: begin
          if (host.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign host.in_ready    = in_ready_q;
  assign host.out_valid   = out_valid_q;
  assign host.product_out = product_q;
  assign host.out_err     = err_q;
  assign dataa            = dataa_q;
  assign datab            = datab_q;
  assign start            = start_q;
  assign count            = count_q;
  assign busy             = busy_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_mult_host_seq.sv
// Bench for mult_host_seq: a cycle-timeline model of the sequencer protocol
// drives done/product_in like the control FSM and datapath would, checks the
// start/count/handshake trace every cycle, and pushes expected results into a
// queue that a separate monitor pops on each output transfer.
module tb_mult_host_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_a;
  always #5 clk = ~clk;

  mult_host_seq_if h ();

  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic        start;
  logic [3:0]  count;
  logic        done;
  logic [15:0] product_in;
  logic        busy;
  logic [2:0]  state_dbg;

  mult_host_seq #(.MAX_RETRY(2)) dut (
    .clk        (clk),
    .reset_a    (reset_a),
    .host       (h.slave),
    .dataa      (dataa),
    .datab      (datab),
    .start      (start),
    .count      (count),
    .done       (done),
    .product_in (product_in),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int          checks = 0;
  int          failures = 0;
  logic [16:0] exp_q[$];      // {out_err, product_out}
  bit          chk_en = 1'b0;
  int          fault_mode = 0; // 0: done every attempt, 1: no done on attempt 1, 2: never done
  bit          or_auto = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- protocol model / control-FSM stand-in ----------------
  // Timeline: accept at cycle T -> attempt start cycle S=T+1; count k at S+1+k;
  // check cycle S+17; retry restarts at S+18, otherwise result from S+18.
  int          cyc = 0;
  int          ps = -1;
  int          att = 0;
  int          mmode = 0;
  bit          m_idle = 1'b1;
  bit          m_out = 1'b0;
  logic [7:0]  ma = '0;
  logic [7:0]  mb = '0;

  always @(negedge clk) begin
    bit exp_start;
    int exp_cnt;
    bit done_now;
    cyc++;
    if (!chk_en) begin
      m_idle = 1'b1;
      m_out = 1'b0;
      ps = -1;
      done = 1'b0;
      product_in = 16'($urandom);
    end else begin
      exp_start = (ps >= 0) && (cyc == ps);
      exp_cnt = ((ps >= 0) && (cyc >= ps + 1) && (cyc <= ps + 16)) ? cyc - ps - 1 : 0;
      check("start", 32'(start), 32'(exp_start));
      check("count", 32'(count), 32'(exp_cnt));
      check("in_ready", 32'(h.in_ready), 32'(m_idle));
      check("busy", 32'(busy), 32'(!m_idle));
      check("out_valid", 32'(h.out_valid), 32'(m_out));
      if (!m_idle) begin
        check("dataa", 32'(dataa), 32'(ma));
        check("datab", 32'(datab), 32'(mb));
      end

      done_now = (ps >= 0) && (cyc == ps + 17) && ((mmode == 0) || (mmode == 1 && att > 1));
      done = done_now;
      product_in = done_now ? 16'(dataa) * 16'(datab) : 16'($urandom);

      if (m_idle && h.in_valid) begin
        ma = h.a_in;
        mb = h.b_in;
        mmode = fault_mode;
        ps = cyc + 1;
        att = 1;
        m_idle = 1'b0;
        if (mmode == 2) exp_q.push_back({1'b1, 16'h0000});
        else            exp_q.push_back({1'b0, 16'(ma) * 16'(mb)});
      end else if ((ps >= 0) && (cyc == ps + 17)) begin
        if (done_now || att == 3) begin
          ps = -1;
          m_out = 1'b1;
        end else begin
          ps = cyc + 1;
          att++;
        end
      end else if (m_out && h.out_ready) begin
        m_out = 1'b0;
        m_idle = 1'b1;
      end
    end
  end

  // ---------------- result monitor ----------------
  always @(negedge clk) begin
    if (!chk_en) begin
      exp_q.delete();
    end else if (h.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none t=%0t", h.product_out, $time);
      end else begin
        check("product_out", 32'(h.product_out), 32'(exp_q[0][15:0]));
        check("out_err", 32'(h.out_err), 32'(exp_q[0][16]));
        if (h.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- consumer ----------------
  always @(posedge clk) begin
    #1;
    if (or_auto) h.out_ready = ($urandom_range(0, 3) != 0);
    else         h.out_ready = 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] a, input logic [7:0] b, input int mode);
    int n;
    @(posedge clk);
    #1;
    fault_mode = mode;
    h.in_valid = 1'b1;
    h.a_in = a;
    h.b_in = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (h.in_ready) break;
      n++;
      if (n > 300) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=no_accept required=accept t=%0t", $time);
        break;
      end
    end
    @(posedge clk);
    #1;
    h.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !h.out_valid) break;
      n++;
      if (n > 400) begin
        checks++;
        failures++;
        $display("FAIL idle_timeout actual=busy required=idle t=%0t", $time);
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(h.in_ready), 0);
    check({tag, "_start"}, 32'(start), 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_out_valid"}, 32'(h.out_valid), 0);
    check({tag, "_product_out"}, 32'(h.product_out), 0);
    check({tag, "_out_err"}, 32'(h.out_err), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_dataa"}, 32'(dataa), 0);
    check({tag, "_datab"}, 32'(datab), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    reset_a = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int m;
    reset_a = 1'b1;
    h.in_valid = 1'b0;
    h.a_in = '0;
    h.b_in = '0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    release_reset();

    // Fault-free path with extreme operands.
    send(8'hFF, 8'hFF, 0);
    wait_idle();

    // Missing done on attempt 1, then recovery.
    send(8'($urandom), 8'($urandom), 1);
    wait_idle();

    // done never arrives: three starts, then the error result.
    send(8'($urandom), 8'($urandom), 2);
    wait_idle();

    // Consumer stalls 5 cycles in OUT while the next pair waits on in_valid.
    or_auto = 1'b0;
    send(8'($urandom), 8'($urandom), 0);
    fork
      send(8'($urandom), 8'($urandom), 0);
      begin
        n = 0;
        while (!h.out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(posedge clk);
        #1;
        or_auto = 1'b1;
      end
    join
    wait_idle();

    // Randomized mix of fault modes.
    for (int i = 0; i < 8; i++) begin
      m = $urandom_range(0, 4);
      send(8'($urandom), 8'($urandom), (m <= 2) ? 0 : m - 2);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    // Reset mid-RUN discards the transaction.
    send(8'($urandom), 8'($urandom), 0);
    n = 0;
    forever begin
      @(negedge clk);
      if (count == 4'd7) break;
      n++;
      if (n > 100) begin
        checks++;
        failures++;
        $display("FAIL count7_timeout actual=%0d required=7 t=%0t", count, $time);
        break;
      end
    end
    #2;
    reset_a = 1'b1;
    chk_en = 1'b0;
    #1;
    check_all_zero("midreset");
    release_reset();
    send(8'h12, 8'h34, 0);
    wait_idle();

    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
